// File: rtl/seq_magnitude_compare.sv
// Multi-cycle magnitude comparator: walks DIGIT-bit digits MSB first and stops
// at the first unequal digit. The result flags are registered and held until the next result.
module seq_magnitude_compare #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_lt_b,
  output logic             a_geq_b
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [CNT_W-1:0] cnt;
  logic [DIGIT-1:0] dig_a, dig_b;
  logic             last_digit;
  logic             decide;
  logic             accept;

  // ---------------------------------------------------------------------------
  // Digit comparison terms shared by the FSM and the datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    dig_a      = sh_a[WIDTH-1 -: DIGIT];
    dig_b      = sh_b[WIDTH-1 -: DIGIT];
    last_digit = (cnt == CNT_W'(N - 1));
    decide     = (dig_a != dig_b) || last_digit;
    // A new compare can be accepted from IDLE and also from FIN (back-to-back).
    accept     = start && (state != RUN);
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next-state / outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; combinational blocks use blocking with defaults first.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (decide) state_nxt = FIN;
      FIN:     state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == FIN);
  end

  // ---------------------------------------------------------------------------
  // Operand shift registers
  // ---------------------------------------------------------------------------
  // NOTE: the shift registers are deliberately left without reset; they are
  // always loaded on accept before RUN reads them, so reset would only add fan-out.
  always_ff @(posedge clk) begin
    if (accept) begin
      // Flipping the sign bit maps two's-complement order onto unsigned order.
      sh_a <= {a[WIDTH-1] ^ signed_mode, a[WIDTH-2:0]};
      sh_b <= {b[WIDTH-1] ^ signed_mode, b[WIDTH-2:0]};
    end else if (state == RUN && !decide) begin
      sh_a <= sh_a << DIGIT;
      sh_b <= sh_b << DIGIT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                         cnt <= '0;
    else if (accept)                   cnt <= '0;
    else if (state == RUN && !decide)  cnt <= cnt + CNT_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Result flags: updated only on the edge that enters FIN
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      a_gt_b  <= 1'b0;
      a_eq_b  <= 1'b0;
      a_lt_b  <= 1'b0;
      a_geq_b <= 1'b0;
    end else if (state == RUN && decide) begin
      a_gt_b  <= (dig_a >  dig_b);
      a_eq_b  <= (dig_a == dig_b);
      a_lt_b  <= (dig_a <  dig_b);
      a_geq_b <= (dig_a >= dig_b);
    end
  end

endmodule

// File: tb/tb_seq_magnitude_compare.sv
// Self-checking bench for seq_magnitude_compare: directed scenarios plus random
// compares on an 8-bit/2-bit-digit instance and a 16-bit/1-bit-digit instance.
module tb_seq_magnitude_compare;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start8, sm8, start16, sm16;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        busy8, done8, gt8, eq8, lt8, geq8;
  logic        busy16, done16, gt16, eq16, lt16, geq16;

  int checks = 0;
  int errors = 0;

  seq_magnitude_compare #(.WIDTH(8), .DIGIT(2)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .signed_mode(sm8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .a_gt_b(gt8), .a_eq_b(eq8), .a_lt_b(lt8), .a_geq_b(geq8)
  );

  seq_magnitude_compare #(.WIDTH(16), .DIGIT(1)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .signed_mode(sm16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .a_gt_b(gt16), .a_eq_b(eq16), .a_lt_b(lt16), .a_geq_b(geq16)
  );

  // Reference model: plain arithmetic compare; latency from the first differing digit.
  function automatic void model(input int w, input int d, input logic [31:0] x,
                                input logic [31:0] y, input bit s, output int lat,
                                output logic [3:0] flags);
    longint va, vb;
    logic [31:0] diff;
    int p;
    va = longint'(x);
    vb = longint'(y);
    if (s && x[w-1]) va = va - (longint'(1) << w);
    if (s && y[w-1]) vb = vb - (longint'(1) << w);
    flags = {va > vb, va == vb, va < vb, va >= vb};
    diff  = x ^ y;
    p     = -1;
    for (int i = 0; i < w; i++) if (diff[i]) p = i;
    lat = (p < 0) ? (w / d + 1) : ((w - 1 - p) / d + 2);
  endfunction

  function automatic logic [3:0] flags_of(input bit sel);
    return sel ? {gt16, eq16, lt16, geq16} : {gt8, eq8, lt8, geq8};
  endfunction

  // Called at the negedge of cycle 0: drives the request for that cycle.
  task automatic launch(input bit sel, input logic [15:0] x, input logic [15:0] y, input bit s);
    if (sel) begin start16 = 1'b1; a16 = x; b16 = y; sm16 = s; end
    else begin start8 = 1'b1; a8 = x[7:0]; b8 = y[7:0]; sm8 = s; end
  endtask

  // Steps through cycles 1..max_cyc, drops start and scrambles operands after
  // cycle 0, and reports done latency (-1 on timeout) plus busy/done pattern errors.
  task automatic measure(input bit sel, input int max_cyc, output int lat, output int bad);
    logic [31:0] r;
    logic bz, dn;
    lat = -1;
    bad = 0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (c == 1) begin
        r = $urandom;
        start8 = 1'b0; start16 = 1'b0;
        if (sel) begin a16 = r[15:0]; b16 = r[31:16]; sm16 = r[0]; end
        else begin a8 = r[7:0]; b8 = r[15:8]; sm8 = r[16]; end
      end
      bz = sel ? busy16 : busy8;
      dn = sel ? done16 : done8;
      if (dn) begin
        if (bz) bad++;
        lat = c;
        break;
      end
      if (!bz) bad++;
    end
  endtask

  task automatic run_case(input string name, input bit sel, input logic [15:0] x,
                          input logic [15:0] y, input bit s);
    int lat, bad, exp_lat;
    logic [3:0] exp_f;
    model(sel ? 16 : 8, sel ? 1 : 2, {16'h0, x}, {16'h0, y}, s, exp_lat, exp_f);
    launch(sel, x, y, s);
    measure(sel, 40, lat, bad);
    checks++;
    if (lat !== exp_lat || bad != 0) begin
      errors++;
      $display("FAIL %s latency: got %0d (busy errs %0d) expected %0d", name, lat, bad, exp_lat);
    end
    checks++;
    if (flags_of(sel) !== exp_f) begin
      errors++;
      $display("FAIL %s flags gt/eq/lt/geq: got %b expected %b", name, flags_of(sel), exp_f);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start8 = 1'b0; start16 = 1'b0; sm8 = 1'b0; sm16 = 1'b0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy8, done8, gt8, eq8, lt8, geq8, busy16, done16, gt16, eq16, lt16, geq16} !== 12'h0) begin
      errors++;
      $display("FAIL reset outputs: got %b%b%b%b%b%b %b%b%b%b%b%b expected all 0",
               busy8, done8, gt8, eq8, lt8, geq8, busy16, done16, gt16, eq16, lt16, geq16);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_case("early_c3_43", 1'b0, 16'hC3, 16'h43, 1'b0);
    run_case("equal_5a", 1'b0, 16'h5A, 16'h5A, 1'b0);
    run_case("late_12_13", 1'b0, 16'h12, 16'h13, 1'b0);
    run_case("signed_80_7f", 1'b0, 16'h80, 16'h7F, 1'b1);
    run_case("unsigned_80_7f", 1'b0, 16'h80, 16'h7F, 1'b0);
    run_case("signed_ff_fe", 1'b0, 16'hFF, 16'hFE, 1'b1);
    run_case("w16_equal_ffff", 1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
  endtask

  task automatic test_ignore_start();
    int lat;
    launch(1'b0, 16'h5A, 16'h5A, 1'b0);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start8 = (c == 2);
      if (c == 2) begin a8 = 8'h00; b8 = 8'h5A; end
      if (done8) begin lat = c; break; end
    end
    start8 = 1'b0;
    checks++;
    if (lat != 5 || {gt8, eq8, lt8, geq8} !== 4'b0101) begin
      errors++;
      $display("FAIL ignore_start: got lat %0d flags %b expected lat 5 flags 0101",
               lat, {gt8, eq8, lt8, geq8});
    end
  endtask

  task automatic test_back_to_back();
    int lat, bad;
    launch(1'b0, 16'hC3, 16'h43, 1'b0);
    measure(1'b0, 20, lat, bad);
    // Now in the FIN cycle: hold start high for the next request.
    run_case("back_to_back_01_02", 1'b0, 16'h01, 16'h02, 1'b0);
  endtask

  task automatic test_hold();
    logic [3:0] held;
    held = {gt8, eq8, lt8, geq8};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if ({gt8, eq8, lt8, geq8} !== 4'b0010 || busy8 || done8) begin
        errors++;
        $display("FAIL hold cycle %0d: got flags %b busy %b done %b expected 0010 0 0 (was %b)",
                 c, {gt8, eq8, lt8, geq8}, busy8, done8, held);
      end
    end
  endtask

  task automatic test_reset_mid(input bit sel);
    int seen;
    launch(sel, sel ? 16'hFFFF : 16'h5A, sel ? 16'hFFFF : 16'h5A, 1'b0);
    @(negedge clk);                    // cycle 1
    start8 = 1'b0; start16 = 1'b0;
    @(negedge clk);                    // cycle 2
    reset = 1'b1;
    @(negedge clk);                    // cycle 3
    reset = 1'b0;
    checks++;
    if ((sel ? {busy16, done16, gt16, eq16, lt16, geq16}
             : {busy8, done8, gt8, eq8, lt8, geq8}) !== 6'h0) begin
      errors++;
      $display("FAIL reset_mid[%0d] cycle 3: got %b expected 000000", sel,
               sel ? {busy16, done16, gt16, eq16, lt16, geq16} : {busy8, done8, gt8, eq8, lt8, geq8});
    end
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (sel ? done16 : done8) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mid[%0d] stray done: got %0d pulses expected 0", sel, seen);
    end
    run_case(sel ? "after_reset16_07_03" : "after_reset8_07_03", sel, 16'h07, 16'h03, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [15:0] x, y;
    for (int i = 0; i < 60; i++) begin
      bit sel;
      r   = $urandom;
      sel = (i % 3 == 2);
      x   = r[15:0];
      case ($urandom_range(0, 3))
        0:       y = x;
        1:       y = x ^ (16'h1 << $urandom_range(0, sel ? 15 : 7));
        default: y = r[31:16];
      endcase
      if (!sel) begin x[15:8] = 8'h0; y[15:8] = 8'h0; end
      run_case(sel ? "random16" : "random8", sel, x, y, r[5]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_hold();
    test_reset_mid(1'b0);
    test_reset_mid(1'b1);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/seq_magnitude_compare.md
Name: seq_magnitude_compare

Overview:
- Parametrised, multi-cycle magnitude comparator for WIDTH-bit operands.
- Compares DIGIT bits per clock, MSB digit first, and terminates early on the first unequal digit.
- Produces registered greater, equal, less and greater-or-equal flags, with a selectable signed or unsigned mode.
- Sits beside the Mini_ALU datapath as the compare unit for operands wider than the fixed 8-bit combinational comparator handles economically; it uses a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand width in bits; must be an integer multiple of DIGIT and at least 2.
- DIGIT, 2, bits compared per cycle; 1 <= DIGIT <= WIDTH.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a compare; sampled only when busy=0.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while a compare is in progress.
- done  output  1  one-cycle pulse when a result is valid.
- a_gt_b  output  1  registered result, A > B.
- a_eq_b  output  1  registered result, A == B.
- a_lt_b  output  1  registered result, A < B.
- a_geq_b  output  1  registered result, A >= B (equals a_gt_b | a_eq_b).

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: state IDLE; busy, done, a_gt_b, a_eq_b, a_lt_b and a_geq_b all 0; digit counter 0. Reset has priority over every other input in the same cycle.
- N = WIDTH/DIGIT digits. Digit 1 is bits [WIDTH-1 : WIDTH-DIGIT].
- States:
  - IDLE: busy=0. On start=1:
    - Latch a and b into shift registers.
    - If signed_mode=1, invert bit WIDTH-1 of both latched copies. This maps two's-complement order onto unsigned order.
    - Clear the digit counter and go to RUN.
  - RUN: busy=1. Each cycle compares the top DIGIT bits of both shift registers as unsigned values.
    - Digits differ: register gt or lt accordingly, then go to FIN.
    - Digits equal and this is digit N: register eq, then go to FIN.
    - Otherwise: shift both registers left by DIGIT, increment the counter and stay in RUN.
  - FIN: busy=0, done=1 for exactly this cycle.
    - start=1 here is accepted as in IDLE and goes directly to RUN (back-to-back operation).
    - Otherwise go to IDLE.
- Latency: if the start edge is cycle 0 and the deciding digit is k (1..N), done is high in cycle k+1.
  - Best case: 2 cycles.
  - Equal operands: N+1 cycles.
- Result outputs:
  - Update only on the edge that enters FIN; they hold until the next result or reset.
  - After the first result, exactly one of gt, eq, lt is 1, and a_geq_b = a_gt_b | a_eq_b.
  - Before the first result, all four are 0.
- start while busy=1 is ignored; no queuing, no error.
- a, b and signed_mode changing during RUN have no effect.
- Reset asserted in RUN or FIN: abort, and all outputs return to reset values on the next cycle. No done is issued for the aborted compare.
- DIGIT=WIDTH degenerates to a single RUN cycle, giving a latency of 2.
- No combinational path from inputs to outputs.

Test Plan:
All cases use WIDTH=8 and DIGIT=2 unless stated.
1. Early decision: unsigned, a=0xC3, b=0x43, start pulsed in cycle 0 -> busy=1 in cycle 1 only; done=1 in cycle 2; gt=1, eq=0, lt=0, geq=1.
2. Full-length equal: a=b=0x5A -> busy cycles 1-4; done in cycle 5; eq=1, geq=1.
3. Late difference: a=0x12, b=0x13 -> done in cycle 5; lt=1, geq=0.
4. Signed vs unsigned: a=0x80, b=0x7F.
   - signed_mode=1 -> lt=1, geq=0, done in cycle 2.
   - Repeat with signed_mode=0 -> gt=1, geq=1.
   - Also a=0xFF, b=0xFE, signed -> gt=1.
5. Handshake:
   - start pulsed in cycle 2 of case 2 with a=0x00 -> ignored; result still eq for 0x5A.
   - start held high in the FIN cycle with a=0x01, b=0x02 -> busy in the next cycle; second done reports lt.
   - Results held stable across idle cycles.
6. Reset mid-operation: reset=1 in cycle 2 of case 2 -> cycle 3 shows busy=0, done=0, all flags 0, and no done ever appears. A new start for a=0x07, b=0x03 then yields gt.
   - Repeat with WIDTH=16, DIGIT=1 and a=b=0xFFFF -> done in cycle 17.
